sync_fifo_prog: RTL and testbench

Parametrised single-clock FIFO. Successor to the team's fixed-threshold sync FIFO, with first-word-fall-through output, runtime-programmable almost-full/almost-empty thresholds, occupancy and peak-occupancy outputs, synchronous flush, and sticky overflow/underflow error flags. Used as the general-purpose elastic buffer between datapath stages where software tunes the flow-control thresholds.

---
 rtl/sync_fifo_prog.sv | 134 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FWFT FIFO with programmable thresholds, occupancy and sticky error flags
module sync_fifo_prog #(
    parameter int DW = 24,
    parameter int AW = 4,
    parameter int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] data_in,
    output logic          full,
    output logic          alFull,
    input  logic          pop,
    output logic          vld,
    output logic [DW-1:0] data_out,
    output logic          empty,
    output logic          alEmpty,
    input  logic [CW-1:0] af_thresh,
    input  logic [CW-1:0] ae_thresh,
    output logic [CW-1:0] count,
    output logic [CW-1:0] max_count,
    input  logic          clear_err,
    output logic          ovf,
    output logic          udf
);

    localparam int            DEPTH   = 2 ** AW;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] max_q, max_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          acc_push, acc_pop;
    logic          ovf_set, udf_set;

    // Status is decoded purely from registered occupancy so it never
    // depends combinationally on push/pop.
    assign full      = (cnt_q == DEPTH_C);
    assign empty     = (cnt_q == '0);
    assign vld       = !empty;
    assign alFull    = (cnt_q >= af_thresh);
    assign alEmpty   = (cnt_q <= ae_thresh);
    assign count     = cnt_q;
    assign max_count = max_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;
    assign data_out  = mem_q[rd_ptr_q];

    always_comb begin
        acc_push = push && !full && !flush;
        acc_pop  = pop && vld && !flush;
        ovf_set  = push && full && !flush;
        udf_set  = pop && !vld && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (acc_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (acc_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (acc_push && !acc_pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!acc_push && acc_pop) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        // A same-cycle set beats clear_err so no error event is lost.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clear_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (udf_set) begin
            udf_d = 1'b1;
        end else if (clear_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end

        if (clear_err) begin
            max_d = cnt_d;
        end else if (cnt_d > max_q) begin
            max_d = cnt_d;
        end else begin
            max_d = max_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            max_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            max_q    <= max_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers give it meaning.
    always_ff @(posedge clk) begin
        if (!rst && acc_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - randomized self-checking bench for sync_fifo_prog against a queue model
module tb_sync_fifo_prog;

    localparam int DW    = 24;
    localparam int AW    = 4;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic [CW-1:0] af_thresh = 5'd12;
    logic [CW-1:0] ae_thresh = 5'd2;
    logic          clear_err = 1'b0;
    logic          full, alFull, vld, empty, alEmpty, ovf, udf;
    logic [DW-1:0] data_out;
    logic [CW-1:0] count, max_count;

    int checks = 0;
    int fails  = 0;

    logic [DW-1:0] mq [$];
    bit            m_ovf, m_udf;
    int            m_max;

    logic [16:0] dut_stat;
    assign dut_stat = {full, alFull, vld, empty, alEmpty, count, max_count, ovf, udf};

    sync_fifo_prog #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in),
        .full(full), .alFull(alFull), .pop(pop), .vld(vld), .data_out(data_out),
        .empty(empty), .alEmpty(alEmpty), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .count(count), .max_count(max_count), .clear_err(clear_err), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    // Expected status from the queue model: {full,alFull,vld,empty,alEmpty,count,max,ovf,udf}
    function automatic logic [16:0] model_status();
        int sz = mq.size();
        return {sz == DEPTH, sz >= int'(af_thresh), sz != 0, sz == 0, sz <= int'(ae_thresh),
                5'(sz), 5'(m_max), m_ovf, m_udf};
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic cycle();
        int sz = mq.size();
        bit so, su;
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
            m_max = 0;
        end else begin
            so = push && (sz == DEPTH) && !flush;
            su = pop && (sz == 0) && !flush;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop && sz > 0) void'(mq.pop_front());
                if (push && sz < DEPTH) mq.push_back(data_in);
            end
            m_ovf = so ? 1'b1 : (clear_err ? 1'b0 : m_ovf);
            m_udf = su ? 1'b1 : (clear_err ? 1'b0 : m_udf);
            if (clear_err) m_max = mq.size();
            else if (mq.size() > m_max) m_max = mq.size();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; push = 0; pop = 0; clear_err = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        cycle();
        rst = 0;
        checks++;
        if (dut_stat !== model_status()) begin
            fails++;
            $display("FAIL reset_status: got %h want %h", dut_stat, model_status());
        end
        checks++;
        if ({empty, vld, full, alEmpty, count, max_count, ovf, udf} !== {1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: got empty=%b vld=%b full=%b alEmpty=%b count=%0d max=%0d ovf=%b udf=%b want 1 0 0 1 0 0 0 0",
                     empty, vld, full, alEmpty, count, max_count, ovf, udf);
        end
    endtask

    task automatic test_fill();
        af_thresh = 5'd12;
        for (int i = 1; i <= 16; i++) begin
            push = 1; data_in = 24'(i);
            cycle();
            checks++;
            if (dut_stat !== model_status() || count !== 5'(i) || alFull !== (i >= 12)) begin
                fails++;
                $display("FAIL fill_step%0d: got stat=%h count=%0d alFull=%b want stat=%h count=%0d alFull=%b",
                         i, dut_stat, count, alFull, model_status(), i, i >= 12);
            end
        end
        push = 0;
        checks++;
        if ({full, vld, max_count} !== {1'b1, 1'b1, 5'd16}) begin
            fails++;
            $display("FAIL fill_final: got full=%b vld=%b max=%0d want 1 1 16", full, vld, max_count);
        end
    endtask

    task automatic test_overflow();
        push = 1; data_in = 24'hABCDEF;
        cycle();
        push = 0;
        checks++;
        if ({ovf, count} !== {1'b1, 5'd16} || dut_stat !== model_status()) begin
            fails++;
            $display("FAIL ovf_set: got ovf=%b count=%0d want 1 16", ovf, count);
        end
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (data_out !== 24'(i) || data_out !== mq[0]) begin
                fails++;
                $display("FAIL drain_data%0d: got %h want %h", i, data_out, 24'(i));
            end
            pop = 1;
            cycle();
        end
        pop = 0;
        checks++;
        if (empty !== 1'b1 || dut_stat !== model_status()) begin
            fails++;
            $display("FAIL drain_empty: got stat=%h want %h", dut_stat, model_status());
        end
    endtask

    task automatic test_back_to_back();
        idle();
        clear_err = 1;
        cycle();
        clear_err = 0;
        for (int i = 0; i < 10; i++) begin
            push = 1; data_in = 24'($urandom);
            cycle();
        end
        push = 0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (data_out !== mq[0]) begin
                fails++;
                $display("FAIL b2b_pop%0d: got %h want %h", i, data_out, mq[0]);
            end
            pop = 1;
            cycle();
        end
        pop = 0;
        // Prime one entry so simultaneous push/pop never hits the empty case.
        push = 1; data_in = 24'($urandom);
        cycle();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (data_out !== mq[0]) begin
                fails++;
                $display("FAIL wrap_data%0d: got %h want %h", i, data_out, mq[0]);
            end
            push = 1; pop = 1; data_in = 24'($urandom);
            cycle();
            checks++;
            if (dut_stat !== model_status() || count !== 5'd1 || ovf !== 1'b0 || udf !== 1'b0) begin
                fails++;
                $display("FAIL wrap_stat%0d: got %h want %h", i, dut_stat, model_status());
            end
        end
        idle();
        checks++;
        if (data_out !== mq[0]) begin
            fails++;
            $display("FAIL wrap_last: got %h want %h", data_out, mq[0]);
        end
        pop = 1;
        cycle();
        pop = 0;
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 3; i++) begin
            pop = 1;
            cycle();
        end
        checks++;
        if ({udf, count} !== {1'b1, 5'd0} || dut_stat !== model_status()) begin
            fails++;
            $display("FAIL udf_set: got udf=%b count=%0d want 1 0", udf, count);
        end
        clear_err = 1; pop = 1;
        cycle();
        checks++;
        if (udf !== 1'b1 || dut_stat !== model_status()) begin
            fails++;
            $display("FAIL udf_set_wins: got udf=%b want 1", udf);
        end
        pop = 0;
        cycle();
        clear_err = 0;
        checks++;
        if (udf !== 1'b0 || max_count !== count || dut_stat !== model_status()) begin
            fails++;
            $display("FAIL udf_clear: got udf=%b max=%0d count=%0d want 0 max==count", udf, max_count, count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            push = 1; data_in = 24'($urandom);
            cycle();
        end
        flush = 1; push = 1; pop = 1;
        cycle();
        idle();
        checks++;
        if ({count, empty, ovf, udf, max_count} !== {5'd0, 1'b1, 1'b0, 1'b0, 5'd5} || dut_stat !== model_status()) begin
            fails++;
            $display("FAIL flush: got count=%0d empty=%b ovf=%b udf=%b max=%0d want 0 1 0 0 5",
                     count, empty, ovf, udf, max_count);
        end
    endtask

    task automatic test_thresholds();
        ae_thresh = 5'd2;
        for (int c = 0; c <= 3; c++) begin
            checks++;
            if (count !== 5'(c) || alEmpty !== (c <= 2)) begin
                fails++;
                $display("FAIL ae_count%0d: got count=%0d alEmpty=%b want %0d %b", c, count, alEmpty, c, c <= 2);
            end
            push = 1; data_in = 24'($urandom);
            cycle();
        end
        af_thresh = 5'd17;
        #1;
        checks++;
        if (alFull !== 1'b0) begin
            fails++;
            $display("FAIL af_immediate: got alFull=%b want 0", alFull);
        end
        while (mq.size() < DEPTH) begin
            push = 1; data_in = 24'($urandom);
            cycle();
            checks++;
            if (alFull !== 1'b0 || dut_stat !== model_status()) begin
                fails++;
                $display("FAIL af17_count%0d: got alFull=%b want 0", mq.size(), alFull);
            end
        end
        push = 0;
        af_thresh = 5'd12;
        #1;
        checks++;
        if (alFull !== 1'b1) begin
            fails++;
            $display("FAIL af_retune: got alFull=%b want 1", alFull);
        end
        while (mq.size() > 7) begin
            pop = 1;
            cycle();
        end
        pop = 0;
        rst = 1;
        cycle();
        rst = 0;
        checks++;
        if ({empty, vld, full, alEmpty, count, max_count, ovf, udf} !== {1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0}
            || dut_stat !== model_status()) begin
            fails++;
            $display("FAIL rst_at7: got stat=%h want %h", dut_stat, model_status());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            clear_err = ($urandom_range(0, 15) == 0);
            push      = ($urandom_range(0, 99) < 55);
            pop       = ($urandom_range(0, 99) < 45);
            data_in   = 24'($urandom);
            if ($urandom_range(0, 31) == 0) af_thresh = 5'($urandom_range(0, 18));
            if ($urandom_range(0, 31) == 0) ae_thresh = 5'($urandom_range(0, 18));
            #1;
            checks++;
            if (dut_stat !== model_status() || (mq.size() > 0 && data_out !== mq[0])) begin
                fails++;
                $display("FAIL rand%0d: got stat=%h data=%h want stat=%h data=%h",
                         i, dut_stat, data_out, model_status(), (mq.size() > 0) ? mq[0] : 24'h0);
            end
            cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_flush();
        test_thresholds();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
